// File: rtl/return_stack.sv
// return_stack: LIFO return-address stack with sticky overflow/underflow flags; define RETURN_STACK_WRAP_EN to overwrite the oldest entry on a full push
module return_stack #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_stack,
  input  logic                       pop_stack,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       err_clr,
  output logic [ADDR_W-1:0]          top_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int SP_W = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);
`ifdef RETURN_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [SP_W-1:0]   sp, sp_m1;
  logic              replace, do_push, do_pop, inc_cnt, set_ovf, set_unf;
  assign sp_m1    = sp - SP_W'(1);
  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  assign top_addr = empty ? '0 : mem[sp_m1];
  assign replace  = push_stack && pop_stack && !empty;
  assign do_push  = push_stack && (!pop_stack || empty) && (!full || WRAP);
  assign do_pop   = pop_stack && !push_stack && !empty;
  assign inc_cnt  = do_push && !full;
  assign set_ovf  = push_stack && !pop_stack && full;
  assign set_unf  = pop_stack && empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (replace) mem[sp_m1] <= push_addr;
      if (do_push) mem[sp] <= push_addr;
      sp        <= do_push ? sp + SP_W'(1) : do_pop ? sp_m1 : sp;
      count     <= inc_cnt ? count + CW'(1) : do_pop ? count - CW'(1) : count;
      overflow  <= set_ovf | (overflow & ~err_clr);
      underflow <= set_unf | (underflow & ~err_clr);
    end
  end
endmodule

// File: doc/return_stack.md
# return_stack

Hardware return-address stack sitting beside the fetch stage of the pipelined core. It stores subroutine return addresses on `push_stack` (JSB) and supplies the saved address on `pop_stack` (RET), under control of the jump controller. Its combinational `top_addr` output feeds the PC-source mux leg selected by `sel_PC_src_stack`. The block also tracks occupancy and flags overflow and underflow.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥ 2.
- `ADDR_W`, 12: return-address (PC) width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `push_stack` input 1: write `push_addr` as the new top this edge.
- `pop_stack` input 1: discard the top entry this edge.
- `push_addr` input ADDR_W: return address (PC+1 of the JSB).
- `err_clr` input 1: synchronous clear of the sticky `overflow` and `underflow` flags.
- `top_addr` output ADDR_W: current top entry (combinational from registered state); 0 when empty.
- `count` output $clog2(DEPTH+1): valid entries, 0..DEPTH.
- `empty` output 1: `count == 0`.
- `full` output 1: `count == DEPTH`.
- `overflow` output 1: sticky; set when a push finds the stack full without a simultaneous pop.
- `underflow` output 1: sticky; set when a pop finds the stack empty.

## Operation
- Storage is a DEPTH×ADDR_W register array with a circular top pointer `sp` (log2 DEPTH bits, wraps modulo DEPTH) and `count`.
- `top_addr` = `mem[sp-1]` when `count > 0`, else 0.
- Push only, not full: `mem[sp] <= push_addr`; `sp++`; `count++`.
- Pop only, not empty: `sp--`; `count--`. Memory is not cleared.
- Push and pop together, `count > 0`: replace the top. `mem[sp-1] <= push_addr`; `sp` and `count` are unchanged. No flag is set, even when full.
- Push and pop together, empty: behaves as push only; `underflow` is set.
- Pop when empty: no state change; `underflow` is set.
- Push when full without pop: behaviour depends on the configuration.
- `err_clr` clears both sticky flags. If a flag-setting event occurs in the same cycle as `err_clr`, the set wins.
- Reset (asynchronous, any time, including mid-sequence): `sp = 0`, `count = 0`, all `mem` entries 0, `overflow = 0`, `underflow = 0`. Resulting outputs: `top_addr = 0`, `empty = 1`, `full = 0`.

## Timing
- Zero-latency read. During the cycle `pop_stack` is asserted, `top_addr` already shows the entry being popped. The PC mux samples it in that same cycle.
- Write-to-read latency is 1 cycle. After the push edge, `top_addr` equals the pushed address.
- All flag, `count`, `empty` and `full` updates appear one edge after the causing request.
- No handshake: requests are single-cycle strobes, and every request is consumed on the edge it is sampled.
- Back-to-back push/pop strobes are supported every cycle.

## Configuration
- `RETURN_STACK_WRAP_EN` defined: push when full overwrites the oldest entry.
  - `mem[sp] <= push_addr`; `sp++`; `count` stays DEPTH; `overflow` is set.
  - The most recent DEPTH addresses remain poppable in LIFO order.
- `RETURN_STACK_WRAP_EN` undefined: push when full is dropped.
  - No change to `mem`, `sp` or `count`; `overflow` is set.

## Test plan
- Reset, then 3 pushes (0x010, 0x020, 0x030), then 3 pops.
  - Pushes: `count` steps 1→2→3 and `top_addr` follows each push.
  - Pops: `top_addr` reads 0x030, 0x020, 0x010 in the pop cycles; finally `empty = 1`, `top_addr = 0`, no flags.
- Pop when empty: `count` stays 0 and `underflow = 1`.
  - Next, `err_clr` with no events clears `underflow`.
  - Then `err_clr` together with another empty pop leaves `underflow = 1`.
- With DEPTH=8, push 0x100..0x107 then push 0x1FF.
  - Without macro: `full = 1`, `overflow = 1`, `top_addr = 0x107`; 8 pops yield 0x107..0x100.
  - With macro: `top_addr = 0x1FF`; 8 pops yield 0x1FF, 0x107..0x101, then `empty = 1`.
- Simultaneous push 0x055 + pop with `count = 2` (top 0x044): after the edge, `top_addr = 0x055` and `count = 2`.
  - Same at full: no `overflow`.
  - Same when empty: `count = 1`, `top_addr = 0x055`, `underflow = 1`.
- Assert `rst_n = 0` mid-sequence with `count = 5` and `overflow = 1`, asynchronously between edges.
  - Outputs clear immediately: `count = 0`, `empty = 1`, `top_addr = 0`, `overflow = 0`.
  - A push after release lands with `count = 1`.
